// File: rtl/led_pwm_driver_if.sv
// Configuration write channel of the LED PWM driver: valid/ready handshake
// carrying a channel index, an output mode and a brightness level.
interface led_pwm_driver_if #(
   parameter int PWM_WIDTH = 8
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [4:0]           cfg_channel;
   logic [1:0]           cfg_mode;
   logic [PWM_WIDTH-1:0] cfg_level;

   modport master (
      output cfg_valid,
      output cfg_channel,
      output cfg_mode,
      output cfg_level,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_channel,
      input  cfg_mode,
      input  cfg_level,
      output cfg_ready
   );
endinterface

// File: rtl/led_pwm_driver.sv
// Multi-channel LED driver: prescaled PWM frame counter, per-channel off/on/pwm/blink
// modes, and a single-slot shadow register that updates channels only at frame wraps.
module led_pwm_driver #(
   parameter int CHANNELS    = 8,
   parameter int PRESCALE    = 50,
   parameter int PWM_WIDTH   = 8,
   parameter int BLINK_WIDTH = 9
) (
   input  logic                clock_50,
   input  logic                reset_n,
   input  logic                enable,
   led_pwm_driver_if.slave     cfg,
   output logic                frame_start,
   output logic [CHANNELS-1:0] led
);
   localparam int                   PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]      PS_MAX   = PS_W'(PRESCALE - 1);
   localparam logic [PWM_WIDTH-1:0] PWM_MAX  = {PWM_WIDTH{1'b1}};
   localparam logic [5:0]           CH_LIMIT = 6'(CHANNELS);

   logic [PS_W-1:0]        presc_q, presc_d;
   logic [PWM_WIDTH-1:0]   pwm_q, pwm_d;
   logic [BLINK_WIDTH-1:0] blink_q, blink_d;
   logic                   frame_start_q, frame_start_d;
   logic [CHANNELS-1:0]    led_q, led_d;
   logic [1:0]             mode_q  [CHANNELS];
   logic [1:0]             mode_d  [CHANNELS];
   logic [PWM_WIDTH-1:0]   level_q [CHANNELS];
   logic [PWM_WIDTH-1:0]   level_d [CHANNELS];
   logic                   pending_q, pending_d;
   logic [4:0]             sh_chan_q, sh_chan_d;
   logic [1:0]             sh_mode_q, sh_mode_d;
   logic [PWM_WIDTH-1:0]   sh_level_q, sh_level_d;
   logic                   tick_s, wrap_s, accept_s, chan_ok_s;

   function automatic logic chan_out(input logic [1:0] mode, input logic below,
                                     input logic blink_bit);
      case (mode)
         2'd0:    chan_out = 1'b0;
         2'd1:    chan_out = 1'b1;
         2'd2:    chan_out = below;
         2'd3:    chan_out = blink_bit & below;
         default: chan_out = 1'b0;
      endcase
   endfunction

   assign cfg.cfg_ready = !pending_q;
   assign frame_start   = frame_start_q;
   assign led           = led_q;

   // Timing chain: prescaler -> pwm counter -> blink counter, all frozen while disabled.
   always_comb begin
      tick_s        = enable && (presc_q == PS_MAX);
      wrap_s        = tick_s && (pwm_q == PWM_MAX);
      frame_start_d = wrap_s;
      if (!enable) begin
         presc_d = presc_q;
      end else if (tick_s) begin
         presc_d = {PS_W{1'b0}};
      end else begin
         presc_d = presc_q + PS_W'(1);
      end
      if (tick_s) begin
         pwm_d = pwm_q + PWM_WIDTH'(1);
      end else begin
         pwm_d = pwm_q;
      end
      if (wrap_s) begin
         blink_d = blink_q + BLINK_WIDTH'(1);
      end else begin
         blink_d = blink_q;
      end
   end

   // Shadow slot: loads on an in-range accepted write, commits only on a frame wrap.
   // Pending blocks new writes, so commit and load can never coincide.
   always_comb begin
      accept_s   = cfg.cfg_valid && !pending_q;
      chan_ok_s  = ({1'b0, cfg.cfg_channel} < CH_LIMIT);
      pending_d  = pending_q;
      sh_chan_d  = sh_chan_q;
      sh_mode_d  = sh_mode_q;
      sh_level_d = sh_level_q;
      mode_d     = mode_q;
      level_d    = level_q;
      if (wrap_s && pending_q) begin
         pending_d = 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            if (sh_chan_q == 5'(i)) begin
               mode_d[i]  = sh_mode_q;
               level_d[i] = sh_level_q;
            end else begin
               mode_d[i]  = mode_q[i];
               level_d[i] = level_q[i];
            end
         end
      end else if (accept_s && chan_ok_s) begin
         pending_d  = 1'b1;
         sh_chan_d  = cfg.cfg_channel;
         sh_mode_d  = cfg.cfg_mode;
         sh_level_d = cfg.cfg_level;
      end else begin
         pending_d = pending_q;
      end
   end

   // Per-channel LED drive from the current counters; forced dark while disabled.
   always_comb begin
      led_d = {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
         if (enable) begin
            led_d[i] = chan_out(mode_q[i], (pwm_q < level_q[i]), blink_q[BLINK_WIDTH-1]);
         end else begin
            led_d[i] = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         presc_q       <= {PS_W{1'b0}};
         pwm_q         <= {PWM_WIDTH{1'b0}};
         blink_q       <= {BLINK_WIDTH{1'b0}};
         frame_start_q <= 1'b0;
         led_q         <= {CHANNELS{1'b0}};
         pending_q     <= 1'b0;
         sh_chan_q     <= 5'd0;
         sh_mode_q     <= 2'd0;
         sh_level_q    <= {PWM_WIDTH{1'b0}};
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]  <= 2'd0;
            level_q[i] <= {PWM_WIDTH{1'b0}};
         end
      end else begin
         presc_q       <= presc_d;
         pwm_q         <= pwm_d;
         blink_q       <= blink_d;
         frame_start_q <= frame_start_d;
         led_q         <= led_d;
         pending_q     <= pending_d;
         sh_chan_q     <= sh_chan_d;
         sh_mode_q     <= sh_mode_d;
         sh_level_q    <= sh_level_d;
         for (int i = 0; i < CHANNELS; i++) begin
            mode_q[i]  <= mode_d[i];
            level_q[i] <= level_d[i];
         end
      end
   end
endmodule
